multicycle_adder: RTL and testbench

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/multicycle_adder_pkg.sv | 13 +
 rtl/multicycle_adder_chunk_adder.sv | 26 ++
 rtl/multicycle_adder.sv | 104 ++++++++++
 tb/tb_multicycle_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multicycle adder: FSM encoding and default sizes.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from one-bit full-adder cells.
// Exposes the carry into the MSB so the caller can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multicycle add/subtract: processes CHUNK bits per clock, WIDTH/CHUNK cycles
// per operation, followed by a one-cycle DONE state that pulses done.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | adding chunk k each cycle, busy=1
// DONE  | results valid, done=1 for one cycle; start here chains a new op
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [KW-1:0]    k;
    logic             last;
    logic             accept;
    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             ch_cmsb;

    assign last   = (k == KW'(NCH - 1));
    assign accept = start && (state == IDLE || state == DONE);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (op_a[k*CHUNK +: CHUNK]),
        .b    (op_b[k*CHUNK +: CHUNK]),
        .cin  (carry),
        .s    (ch_s),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand latch and per-chunk accumulation; cout/ovf only update on the last chunk
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
        end else if (state == RUN) begin
            sum[k*CHUNK +: CHUNK] <= ch_s;
            carry                 <= ch_cout;
            k                     <= k + 1'b1;
            if (last) begin
                cout <= ch_cout;
                ovf  <= ch_cmsb ^ ch_cout;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: WIDTH=16/CHUNK=4 main instance plus a
// single-chunk (CHUNK=16) instance for the two-cycle latency case.
module tb_multicycle_adder;

    logic        clk;
    logic        rst_n;

    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        start2, sub2, cin2;
    logic [15:0] a2, b2;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] sum2;

    int passed = 0;
    int total  = 0;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .Clock(clk), .Resetn(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
        .Clock(clk), .Resetn(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one operation and return cycles from the start-sampling edge to done
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input logic tsub, output int lat);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input logic [15:0] es,
                                input logic ec, input logic eo);
        check({tag, "_lat"},  lat, 32'd5);
        check({tag, "_sum"},  {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"},  {31'd0, ovf}, {31'd0, eo});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {16'd0, sum}, {16'd0, es});
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        start = 0; sub = 0; cin = 0; a = '0; b = '0;
        start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {16'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        check("rst_sum2", {16'd0, sum2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        check_result("add_wrap", lat, 16'h0000, 1'b1, 1'b0);

        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        check_result("sub_borrow", lat, 16'hFFFE, 1'b0, 1'b0);

        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, lat);
        check_result("sub_noborrow", lat, 16'h0002, 1'b1, 1'b0);

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        check_result("ovf_pos", lat, 16'h8000, 1'b0, 1'b1);

        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
        check_result("ovf_neg", lat, 16'h0000, 1'b1, 1'b1);

        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        check_result("add_cin", lat, 16'h5556, 1'b0, 1'b0);

        // start held high across a whole operation with changing operands
        @(negedge clk);
        a = 16'h0100; b = 16'h0023; cin = 0; sub = 0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("held_lat", lat, 32'd5);
        check("held_sum1", {16'd0, sum}, 32'h0123);
        @(negedge clk);
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("held_lat2", lat, 32'd5);
        check("held_sum2", {16'd0, sum}, 32'h3333);

        do_op(16'hFFFF, 16'h0002, 1'b0, 1'b0, lat);
        check_result("pre_rst", lat, 16'h0001, 1'b1, 1'b0);

        // reset during chunk 2 of a run
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_partial_sum", {16'd0, sum}, 32'h0045);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sum",  {16'd0, sum},  32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no_done_after_rst", seen, 32'd0);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        check_result("after_rst", lat, 16'h2345, 1'b0, 1'b0);

        // single-chunk instance: done two cycles after the sampling edge
        @(negedge clk);
        a2 = 16'h1234; b2 = 16'h4321; cin2 = 1'b1; sub2 = 1'b0; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("c16_lat",  lat, 32'd2);
        check("c16_sum",  {16'd0, sum2}, 32'h5556);
        check("c16_cout", {31'd0, cout2}, 32'd0);
        check("c16_ovf",  {31'd0, ovf2}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
